// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB control for the 3-bit CPU datapath.
// Optional single-step support is compiled in with `define SINGLE_STEP_EN.
module multicycle_ctrl #(
  parameter int         CNT_W   = 8,
  parameter logic [6:0] HALT_OP = 7'h7F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [15:0]      ins,
`ifdef SINGLE_STEP_EN
  input  logic             step,
  input  logic             step_mode,
`endif
  output logic [15:0]      ir,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             wr_en,
  output logic             m_wr_en,
  output logic [6:0]       alu_op,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
`ifdef SINGLE_STEP_EN
  localparam logic [2:0] S_FETCH_WAIT = 3'd7;
`endif

  localparam logic [6:0] ALU_PASS_R = 7'b0100000;
  localparam logic [6:0] ALU_PASS_M = 7'b1000000;

  logic [2:0]       state_reg, state_next;
  logic [15:0]      ir_reg;
  logic [CNT_W-1:0] retired_reg;
  logic [2:0]       fetch_entry;

  logic [6:0] opcode;
  logic       is_nop, is_alu, is_ld, is_st, is_jmp, is_halt, is_illegal;
  logic [6:0] alu_onehot;

  assign opcode  = ir_reg[15:9];
  assign is_halt = (opcode == HALT_OP);
  assign is_nop  = (opcode == 7'h00);
  assign is_alu  = (opcode >= 7'h01) && (opcode <= 7'h05);
  assign is_ld   = (opcode == 7'h08);
  assign is_st   = (opcode == 7'h09);
  assign is_jmp  = (opcode == 7'h0A);
  assign is_illegal = !(is_halt || is_nop || is_alu || is_ld || is_st || is_jmp);

  // ALU opcodes 1..5 map onto alu_op bits 0..4
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_alu_dec
      assign alu_onehot[gi] = (opcode == 7'(gi + 1));
    end
  endgenerate
  assign alu_onehot[6:5] = 2'b00;

`ifdef SINGLE_STEP_EN
  assign fetch_entry = step_mode ? S_FETCH_WAIT : S_FETCH;
`else
  assign fetch_entry = S_FETCH;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      ir_reg      <= '0;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_FETCH)
        ir_reg <= ins;
      if ((pc_inc || pc_load) && (retired_reg != {CNT_W{1'b1}}))
        retired_reg <= retired_reg + 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (go) state_next = fetch_entry;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        if (is_halt)              state_next = S_HALT;
        else if (is_alu)          state_next = S_EXEC;
        else if (is_ld || is_st)  state_next = S_MEM;
        else                      state_next = fetch_entry;
      end
      S_EXEC:   state_next = S_WB;
      S_MEM:    state_next = is_ld ? S_WB : fetch_entry;
      S_WB:     state_next = fetch_entry;
      S_HALT:   state_next = S_HALT;
`ifdef SINGLE_STEP_EN
      // Dropping step_mode while parked releases the wait immediately
      S_FETCH_WAIT: if (step || !step_mode) state_next = S_FETCH;
`endif
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    wr_en   = 1'b0;
    m_wr_en = 1'b0;
    alu_op  = '0;
    halted  = 1'b0;
    illegal = 1'b0;
    case (state_reg)
      S_DECODE: begin
        if (is_jmp) begin
          pc_load = 1'b1;
        end else if (is_nop || is_illegal) begin
          pc_inc  = 1'b1;
          illegal = is_illegal;
        end
      end
      S_EXEC: alu_op = alu_onehot;
      S_MEM: begin
        if (is_ld) begin
          alu_op = ALU_PASS_M;
        end else begin
          alu_op  = ALU_PASS_R;
          m_wr_en = 1'b1;
          pc_inc  = 1'b1;
        end
      end
      S_WB: begin
        alu_op = is_ld ? ALU_PASS_M : alu_onehot;
        wr_en  = 1'b1;
        pc_inc = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign ir      = ir_reg;
  assign state   = state_reg;
  assign retired = retired_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed table, random instructions
// against an instruction-level model, and hand-written corner-case sequences.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, go;
  logic [15:0] ins;
  logic [15:0] ir;
  logic        pc_inc, pc_load, wr_en, m_wr_en, halted, illegal;
  logic [6:0]  alu_op;
  logic [2:0]  state;
  logic [7:0]  retired;
`ifdef SINGLE_STEP_EN
  logic        step, step_mode;
`endif

  logic        rst2, go2;
  logic [15:0] ins2, ir2;
  logic        pc_inc2, pc_load2, wr_en2, m_wr_en2, halted2, illegal2;
  logic [6:0]  alu_op2;
  logic [2:0]  state2;
  logic [1:0]  retired2;
`ifdef SINGLE_STEP_EN
  logic        step2, step_mode2;
`endif

  multicycle_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .go(go), .ins(ins),
`ifdef SINGLE_STEP_EN
    .step(step), .step_mode(step_mode),
`endif
    .ir(ir), .pc_inc(pc_inc), .pc_load(pc_load), .wr_en(wr_en), .m_wr_en(m_wr_en),
    .alu_op(alu_op), .state(state), .halted(halted), .illegal(illegal), .retired(retired)
  );

  multicycle_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .go(go2), .ins(ins2),
`ifdef SINGLE_STEP_EN
    .step(step2), .step_mode(step_mode2),
`endif
    .ir(ir2), .pc_inc(pc_inc2), .pc_load(pc_load2), .wr_en(wr_en2), .m_wr_en(m_wr_en2),
    .alu_op(alu_op2), .state(state2), .halted(halted2), .illegal(illegal2), .retired(retired2)
  );

  typedef struct {
    logic [15:0] ins;
    int          cycles;
    int          wr;
    int          mwr;
    int          inc;
    int          load;
    int          ill;
    logic [6:0]  alu;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int exp_ret  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction-level reference: cycles and strobe totals per instruction class
  function automatic vec_t model(input logic [15:0] i);
    vec_t v;
    logic [6:0] op;
    op = i[15:9];
    v.ins = i; v.cycles = 2; v.wr = 0; v.mwr = 0; v.inc = 0; v.load = 0; v.ill = 0; v.alu = '0;
    if (op >= 7'd1 && op <= 7'd5) begin
      v.cycles = 4; v.wr = 1; v.inc = 1; v.alu = 7'(1 << (op - 1));
    end else if (op == 7'h08) begin
      v.cycles = 4; v.wr = 1; v.inc = 1; v.alu = 7'h40;
    end else if (op == 7'h09) begin
      v.cycles = 3; v.mwr = 1; v.inc = 1; v.alu = 7'h20;
    end else if (op == 7'h0A) begin
      v.load = 1;
    end else begin
      v.inc = 1;
      v.ill = (op != 7'h00) ? 1 : 0;
    end
    return v;
  endfunction

  // Runs one instruction starting from a cycle where state==FETCH
  task automatic run_instr(input vec_t v, input string tag);
    int cyc = 0, nwr = 0, nmwr = 0, ninc = 0, nload = 0, nill = 0;
    logic [6:0]  alu_seen = '0;
    logic [15:0] ir_seen  = '0;
    bit overlap = 1'b0;
    ins = v.ins;
    exp_ret = (exp_ret >= 255) ? 255 : exp_ret + 1;
    do begin
      if (state == 3'd2) ir_seen = ir;
      nwr += int'(wr_en); nmwr += int'(m_wr_en); ninc += int'(pc_inc);
      nload += int'(pc_load); nill += int'(illegal);
      if (wr_en || m_wr_en) alu_seen = alu_op;
      if ((wr_en && m_wr_en) || (pc_inc && pc_load)) overlap = 1'b1;
      cyc++;
      tick();
    end while (state != 3'd1 && cyc < 12);
    $display("instr %s ins=%04h cycles=%0d retired=%0d", tag, v.ins, cyc, retired);
    chk({tag, "_cycles"}, cyc, v.cycles);
    chk({tag, "_wr"}, nwr, v.wr);
    chk({tag, "_mwr"}, nmwr, v.mwr);
    chk({tag, "_inc"}, ninc, v.inc);
    chk({tag, "_load"}, nload, v.load);
    chk({tag, "_ill"}, nill, v.ill);
    chk({tag, "_alu"}, alu_seen, v.alu);
    chk({tag, "_overlap"}, overlap, 0);
    chk({tag, "_ir"}, ir_seen, v.ins);
    chk({tag, "_retired"}, retired, exp_ret);
  endtask

  initial begin
    vec_t tbl[10];
    logic [2:0] seq_st[4];
    logic [6:0] seq_alu[4];
    logic       seq_wr[4];
    vec_t v;
    logic [6:0] op;
    int prev, mono_bad;

    tbl[0] = '{ {7'h08, 3'd5, 3'd0, 3'd2}, 4, 1, 0, 1, 0, 0, 7'h40 };
    tbl[1] = '{ {7'h09, 3'd4, 3'd1, 3'd0}, 3, 0, 1, 1, 0, 0, 7'h20 };
    tbl[2] = '{ {7'h0A, 9'h025},           2, 0, 0, 0, 1, 0, 7'h00 };
    tbl[3] = '{ 16'h0000,                  2, 0, 0, 1, 0, 0, 7'h00 };
    tbl[4] = '{ {7'h33, 9'h000},           2, 0, 0, 1, 0, 1, 7'h00 };
    tbl[5] = '{ {7'h02, 9'h01A},           4, 1, 0, 1, 0, 0, 7'h02 };
    tbl[6] = '{ {7'h03, 9'h0FF},           4, 1, 0, 1, 0, 0, 7'h04 };
    tbl[7] = '{ {7'h04, 9'h000},           4, 1, 0, 1, 0, 0, 7'h08 };
    tbl[8] = '{ {7'h05, 9'h1C7},           4, 1, 0, 1, 0, 0, 7'h10 };
    tbl[9] = '{ {7'h7E, 9'h155},           2, 0, 0, 1, 0, 1, 7'h00 };

    rst = 1'b1; go = 1'b0; ins = '0;
    rst2 = 1'b1; go2 = 1'b0; ins2 = '0;
`ifdef SINGLE_STEP_EN
    step = 1'b0; step_mode = 1'b0; step2 = 1'b0; step_mode2 = 1'b0;
`endif
    tick(); tick();
    chk("reset_state", state, 0);
    chk("reset_ir", ir, 0);
    chk("reset_retired", retired, 0);
    chk("reset_strobes", {pc_inc, pc_load, wr_en, m_wr_en, halted, illegal}, 0);
    chk("reset_alu", alu_op, 0);

    // Idle holds without go
    rst = 1'b0;
    tick(); tick();
    chk("idle_hold", state, 0);
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("go_fetch", state, 1);

    // ADD r3: state 1,2,3,5
    seq_st  = '{3'd1, 3'd2, 3'd3, 3'd5};
    seq_alu = '{7'h00, 7'h00, 7'h01, 7'h01};
    seq_wr  = '{1'b0, 1'b0, 1'b0, 1'b1};
    ins = 16'h0200 | 16'd3;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("add_state%0d", k), state, seq_st[k]);
      chk($sformatf("add_alu%0d", k), alu_op, seq_alu[k]);
      chk($sformatf("add_wr%0d", k), wr_en, seq_wr[k]);
      tick();
    end
    exp_ret = 1;
    chk("add_back_fetch", state, 1);
    chk("add_retired", retired, 1);

    for (int t = 0; t < 10; t++) run_instr(tbl[t], $sformatf("tbl%0d", t));

    for (int r = 0; r < 60; r++) begin
      op = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 11));
      if (op == 7'h7F) op = 7'h00;
      v = model({op, 9'($urandom)});
      run_instr(v, $sformatf("rnd%0d", r));
    end

    // JMP then HALT
    ins = {7'h0A, 9'h025};
    tick();
    chk("jmp_pc_load", pc_load, 1);
    chk("jmp_pc_inc", pc_inc, 0);
    chk("jmp_target", ir[6:0], 7'h25);
    tick();
    exp_ret = (exp_ret >= 255) ? 255 : exp_ret + 1;
    ins = {7'h7F, 9'h000};
    go = 1'b1;
    tick(); tick();
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("halt_hold%0d", k), {state, halted}, {3'd6, 1'b1});
      tick();
    end
    chk("halt_retired", retired, exp_ret);
    go = 1'b0;

    // Illegal opcode pulse, then reset mid-EXEC
    rst = 1'b1; tick(); rst = 1'b0; go = 1'b1; tick(); go = 1'b0;
    ins = {7'h33, 9'h000};
    tick();
    chk("ill_pulse", {illegal, pc_inc}, 2'b11);
    tick();
    chk("ill_drop", illegal, 0);
    chk("ill_retired", retired, 1);
    ins = 16'h0203;
    tick(); tick();
    chk("exec_state", state, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_exec_state", state, 0);
    chk("rst_exec_wr", wr_en, 0);
    chk("rst_exec_retired", retired, 0);

    // Saturation with a 2-bit counter
    rst2 = 1'b0; go2 = 1'b1;
    prev = 0; mono_bad = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (int'(retired2) < prev) mono_bad = 1;
      prev = int'(retired2);
    end
    chk("sat_no_wrap", mono_bad, 0);
    chk("sat_retired", retired2, 3);

`ifdef SINGLE_STEP_EN
    step_mode = 1'b1;
    rst = 1'b1; tick(); rst = 1'b0; go = 1'b1; tick(); go = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("step_wait%0d", k), state, 7);
      tick();
    end
    ins = 16'h0000;
    step = 1'b1; tick(); step = 1'b0;
    chk("step_fetch", state, 1);
    tick(); tick();
    chk("step_return", state, 7);
    chk("step_retired", retired, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the 3-bit CPU datapath. It replaces the single-cycle CU decode path and steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It holds the instruction register and generates PC, register-file, memory and ALU controls, and it counts retired instructions. It sits between InsMem and PC/RegFiles/ALU/Memory inside CPU.

Parameters:
CNT_W, 8, width of the retired-instruction counter (saturating)
HALT_OP, 7'h7F, opcode value that halts the core

Ports:
clk  in  1  system clock, all state changes on rising edge
rst  in  1  synchronous, active-high reset
go  in  1  leaves IDLE when sampled high
ins  in  16  instruction from InsMem at the current PC
ir  out  16  latched instruction; [8:6] memory addr, [5:3] rt, [2:0] rd, [6:0] jump target
pc_inc  out  1  PC += 1 at the next edge
pc_load  out  1  PC <= ir[6:0] at the next edge
wr_en  out  1  register-file write strobe
m_wr_en  out  1  data-memory write strobe
alu_op  out  7  one-hot: b0 ADD, b1 SUB, b2 AND, b3 OR, b4 XOR, b5 PASS_R, b6 PASS_M
state  out  3  current state encoding, for debug
halted  out  1  high while in HALT
illegal  out  1  one-cycle pulse when an undefined opcode is decoded
retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset (synchronous): state=IDLE(0), ir=0, retired=0, and every strobe, alu_op, halted and illegal = 0. A reset in any state, including mid-instruction, aborts the instruction with no write strobe issued.
- Opcode = ir[15:9]:
  - 0x00 NOP
  - 0x01 ADD, 0x02 SUB, 0x03 AND, 0x04 OR, 0x05 XOR
  - 0x08 LD (mem[ir[8:6]] -> rd)
  - 0x09 ST (reg rt -> mem[ir[8:6]])
  - 0x0A JMP
  - HALT_OP
  - All other values are illegal and execute as NOP.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Outputs are Moore decodes of state and ir. alu_op is 0 unless stated below.
- IDLE: go=1 -> FETCH; otherwise stay.
- FETCH: ir <= ins at the clock edge -> DECODE.
- DECODE:
  - NOP or illegal: pc_inc=1 -> FETCH. illegal=1 for illegal opcodes only.
  - JMP: pc_load=1 -> FETCH.
  - HALT_OP -> HALT.
  - ALU op -> EXEC.
  - LD or ST -> MEM.
- EXEC: alu_op = onehot(opcode-1) -> WB.
- MEM:
  - LD: alu_op=b6 -> WB.
  - ST: alu_op=b5, m_wr_en=1, pc_inc=1 -> FETCH.
- WB: alu_op keeps its EXEC/MEM value, wr_en=1, pc_inc=1 -> FETCH.
- HALT: halted=1. Stays in HALT until rst; go is ignored.
- Cycles per instruction: NOP/JMP/illegal 2, ST 3, ALU/LD 4. HALT is terminal.
- Exactly one of pc_inc/pc_load is asserted per retired instruction. wr_en and m_wr_en are never high in the same cycle.
- retired increments by 1 in every cycle where pc_inc|pc_load=1. It saturates at 2^CNT_W-1 and does not wrap. HALT is not counted.
- PC wrap (0x7F+1 -> 0) is owned by PC; the controller does not special-case it.
- go held high or pulsed has the same effect: it is sampled only in IDLE.

Optional Feature:
SINGLE_STEP_EN. When defined, add input ports step (1) and step_mode (1).
- With step_mode=1, FETCH is entered only from a new wait sub-state FETCH_WAIT(7), which advances to FETCH on step=1. All completed instructions return to FETCH_WAIT instead of FETCH.
- With step_mode=0, behaviour is identical to the feature being absent.
When not defined, the ports and state 7 do not exist, and state 7 is unreachable.

Test Plan:
- Reset then go=1 with ins=16'h0200|rd=3 (ADD) -> state sequence 1,2,3,5. alu_op=7'b0000001 in EXEC and WB. wr_en=1 only in WB. retired=1.
- LD ins={7'h08,3'd5,3'd0,3'd2} -> MEM alu_op=7'b1000000, WB wr_en=1, ir[2:0]=2. Total 4 cycles FETCH..WB.
- ST ins={7'h09,3'd4,3'd1,3'd0} -> MEM cycle has m_wr_en=1, pc_inc=1 and alu_op=7'b0100000. The next state is FETCH, and wr_en is never asserted.
- JMP ins={7'h0A,9'h025} -> DECODE asserts pc_load=1 with ir[6:0]=7'h25 and pc_inc=0. Then opcode 7'h7F -> halted=1 and stays high for 10 cycles with go=1. retired is unchanged.
- Opcode 7'h33 -> illegal=1 for exactly one cycle in DECODE, pc_inc=1, retired incremented. Assert rst during an EXEC cycle -> the next cycle has state=0, wr_en=0 and retired=0.
- CNT_W=2, run 5 NOPs -> retired saturates at 3. With SINGLE_STEP_EN and step_mode=1, the controller stays in state 7 until step is pulsed, then runs one instruction and returns to 7.
